decode_issue_stage: RTL
=======================

// Module: decode_issue_stage
// PURPOSE
//   ID stage of the MIPS pipeline, directly upstream of the register file.
//   - Takes the fetched instruction and drives the register-file read addresses.
//   - Captures the operands and decoded control into an ID/EX register with a
//     valid/ready handshake toward EX.
//   - Detects load-use hazards and inserts a one-cycle bubble for each.
// PARAMETERS
//   DATA_W    32     operand / instruction width
//   CNT_W     16     width of the hazard-bubble counter
//   LW_OPCODE 6'h23  opcode treated as a load (sets memread)
// PORTS
//   clk          in   1       pipeline clock, all state updates on posedge
//   rst_n        in   1       asynchronous active-low reset
//   if_valid     in   1       if_instr is valid
//   if_ready     out  1       stage accepts if_instr this cycle
//   if_instr     in   DATA_W  instruction from IF
//   rf_a1        out  5       regfile read address 1 = if_instr[25:21] (rs)
//   rf_a2        out  5       regfile read address 2 = if_instr[20:16] (rt)
//   rf_rd1       in   DATA_W  regfile read data 1, valid before the next posedge
//   rf_rd2       in   DATA_W  regfile read data 2
//   wb_regwrite  in   1       writeback write enable, same as regfile regwrite
//   wb_a3        in   5       writeback destination address
//   wb_wd3       in   DATA_W  writeback data
//   flush        in   1       kill ID/EX contents (branch redirect)
//   ex_valid     out  1       ID/EX bundle valid
//   ex_ready     in   1       EX consumes the bundle this cycle
//   ex_opcode    out  6       instr[31:26]
//   ex_funct     out  6       instr[5:0]
//   ex_rs_val    out  DATA_W  rs operand
//   ex_rt_val    out  DATA_W  rt operand
//   ex_imm       out  DATA_W  extended immediate
//   ex_dst       out  5       destination register
//   ex_regwrite  out  1       instruction writes a register
//   ex_memread   out  1       instruction is a load
//   stall_cnt    out  CNT_W   count of load-use bubbles inserted
// BEHAVIOUR
//   - Reset: every ex_* output and stall_cnt is 0; if_ready is 0 while rst_n=0.
//   - rf_a1/rf_a2 are combinational from if_instr and carry no register stage.
//   - State is the ex_valid bit: EMPTY (0) or FULL (1).
//   - free = !ex_valid | ex_ready.
//   - hazard = ex_valid & ex_memread & (ex_dst!=0) & (ex_dst==rs | ex_dst==rt).
//   - if_ready = free & !hazard & !flush.
//   - On posedge, in priority order:
//     1. flush: ex_valid<=0. Other fields don't-care. No instruction is accepted.
//     2. free & if_valid & !hazard: load the bundle, ex_valid<=1.
//        Latency is 1 cycle from acceptance to ex_valid.
//     3. free & hazard: ex_valid<=0 (bubble), stall_cnt+=1, saturating at
//        all-ones. The hazard clears on the next cycle, so each load-use
//        costs exactly one bubble.
//     4. free & !if_valid: ex_valid<=0.
//     5. !free: hold every ex_* output unchanged, no counting.
//   - Decode:
//     - ex_dst = (opcode==0) ? instr[15:11] : instr[20:16].
//     - ex_regwrite = 1 for opcode 0x00, 0x08, 0x0A, 0x0C, 0x0D, LW_OPCODE;
//       else 0.
//     - ex_memread = (opcode==LW_OPCODE).
//     - ex_imm zero-extended for 0x0C/0x0D, sign-extended otherwise.
//   - Register 0 always reads 0 into ex_rs_val/ex_rt_val, whatever rf_rd*
//     shows.
//   - Reset asserted mid-transfer drops the bundle; there is no replay.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     - A write landing on the same posedge that captures the operands is not
//       yet visible on rf_rd*, so it is bypassed.
//     - If wb_regwrite & wb_a3!=0 & wb_a3==rs, ex_rs_val<=wb_wd3 instead of
//       rf_rd1.
//     - Same rule for rt with rf_rd2.
//   WB_BYPASS_EN undefined:
//     - Operands come only from rf_rd1/rf_rd2 (or 0 for register 0).
//     - Software or the compiler must schedule one gap after a writeback.
// TESTING
//   1. Assert rst_n=0 mid-run, then release -> ex_valid=0, stall_cnt=0, all
//      ex_* = 0 until the first accepted instr.
//   2. add $3,$1,$2 (0x00221820), rf_rd1=1, rf_rd2=2, ex_ready=1 -> next cycle
//      ex_valid=1, rs_val=1, rt_val=2, dst=3, regwrite=1.
//   3. lw $4,0($1) then add $5,$4,$2 -> one bubble (ex_valid=0), if_ready=0
//      for that cycle, stall_cnt=1, add issues the following cycle.
//   4. ex_ready=0 for 3 cycles with a FULL stage -> ex_* stable, if_ready=0,
//      no stall_cnt change.
//   5. flush=1 with if_valid=1 -> ex_valid=0 next cycle, instr not consumed
//      (if_ready=0).
//   6. WB_BYPASS_EN: wb_regwrite=1, wb_a3=1, wb_wd3=0xDEAD while issuing
//      add $3,$1,$2 -> rs_val=0xDEAD. Without the macro, rs_val=rf_rd1.
//      Write to $0 is never bypassed.

Source files
------------

// File: rtl/decode_issue_stage.sv
// ============================================================================
// Module   : decode_issue_stage
// Purpose  : MIPS ID stage. Drives regfile reads, decodes into an ID/EX
//            register with valid/ready toward EX, inserts load-use bubbles.
// Config   : WB_BYPASS_EN - forward same-edge writeback data into operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue_stage #(
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 16,
  parameter logic [5:0]  LW_OPCODE = 6'h23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [DATA_W-1:0] if_instr_i,
  output logic [4:0]        rf_a1_o,
  output logic [4:0]        rf_a2_o,
  input  logic [DATA_W-1:0] rf_rd1_i,
  input  logic [DATA_W-1:0] rf_rd2_i,
  input  logic              wb_regwrite_i,
  input  logic [4:0]        wb_a3_i,
  input  logic [DATA_W-1:0] wb_wd3_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [5:0]        ex_opcode_o,
  output logic [5:0]        ex_funct_o,
  output logic [DATA_W-1:0] ex_rs_val_o,
  output logic [DATA_W-1:0] ex_rt_val_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_dst_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [5:0]          funct_q, funct_d;
  logic [DATA_W-1:0]   rs_val_q, rs_val_d;
  logic [DATA_W-1:0]   rt_val_q, rt_val_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [4:0]          dst_q, dst_d;
  logic                regwrite_q, regwrite_d;
  logic                memread_q, memread_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [5:0]          opcode;
  logic [4:0]          rs, rt, rd;
  logic [15:0]         imm16;
  logic                dec_regwrite;
  logic [DATA_W-1:0]   dec_imm;
  logic [DATA_W-1:0]   rs_sel, rt_sel;
  logic                free, hazard;

  assign opcode  = if_instr_i[31:26];
  assign rs      = if_instr_i[25:21];
  assign rt      = if_instr_i[20:16];
  assign rd      = if_instr_i[15:11];
  assign imm16   = if_instr_i[15:0];
  assign rf_a1_o = rs;
  assign rf_a2_o = rt;

  assign free   = (state_q == EMPTY) | ex_ready_i;
  assign hazard = (state_q == FULL) & memread_q & (dst_q != 5'd0) &
                  ((dst_q == rs) | (dst_q == rt));
  // Gated by rst_n so upstream never sees a handshake while in reset.
  assign if_ready_o = rst_n & free & ~hazard & ~flush_i;

  always_comb begin
    dec_regwrite = 1'b0;
    case (opcode)
      6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D: dec_regwrite = 1'b1;
      default:                           dec_regwrite = (opcode == LW_OPCODE);
    endcase
  end

  assign dec_imm = ((opcode == 6'h0C) || (opcode == 6'h0D)) ?
                   {{(DATA_W-16){1'b0}}, imm16} :
                   {{(DATA_W-16){imm16[15]}}, imm16};

`ifdef WB_BYPASS_EN
  // A same-edge writeback is not yet visible on rf_rd*, so forward it.
  always_comb begin
    rs_sel = rf_rd1_i;
    rt_sel = rf_rd2_i;
    if (rs == 5'd0)
      rs_sel = '0;
    else if (wb_regwrite_i && (wb_a3_i == rs))
      rs_sel = wb_wd3_i;
    if (rt == 5'd0)
      rt_sel = '0;
    else if (wb_regwrite_i && (wb_a3_i == rt))
      rt_sel = wb_wd3_i;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite_i, wb_a3_i, wb_wd3_i};
  assign rs_sel    = (rs == 5'd0) ? '0 : rf_rd1_i;
  assign rt_sel    = (rt == 5'd0) ? '0 : rf_rd2_i;
`endif

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    funct_d     = funct_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    imm_d       = imm_q;
    dst_d       = dst_q;
    regwrite_d  = regwrite_q;
    memread_d   = memread_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (free) begin
      if (if_valid_i && !hazard) begin
        state_d    = FULL;
        opcode_d   = opcode;
        funct_d    = if_instr_i[5:0];
        rs_val_d   = rs_sel;
        rt_val_d   = rt_sel;
        imm_d      = dec_imm;
        dst_d      = (opcode == 6'h00) ? rd : rt;
        regwrite_d = dec_regwrite;
        memread_d  = (opcode == LW_OPCODE);
      end else if (hazard) begin
        state_d = EMPTY;
        if (stall_cnt_q != {CNT_W{1'b1}})
          stall_cnt_d = stall_cnt_q + 1'b1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      opcode_q    <= '0;
      funct_q     <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      dst_q       <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      funct_q     <= funct_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      dst_q       <= dst_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o    = (state_q == FULL);
  assign ex_opcode_o   = opcode_q;
  assign ex_funct_o    = funct_q;
  assign ex_rs_val_o   = rs_val_q;
  assign ex_rt_val_o   = rt_val_q;
  assign ex_imm_o      = imm_q;
  assign ex_dst_o      = dst_q;
  assign ex_regwrite_o = regwrite_q;
  assign ex_memread_o  = memread_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

`default_nettype wire
